fifo_wr_arbiter: RTL and testbench

Round-robin, burst-locking arbiter that shares the single write port of the UART/IO `fifo` between `NUM_REQ` valid/ready producers, such as the CPU MMIO store path and DMA-style fill engines. It sits directly in front of the FIFO's `wr_en`/`din`/`full` pins. It grants one producer at a time for up to `BURST` beats and then rotates priority so that no producer starves.

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_wr_arbiter_if.sv | 45 ++++
 rtl/fifo_wr_arbiter_rr_pick.sv | 49 ++++
 rtl/fifo_wr_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// +----------------------------------------------------------------------+
// | fifo_arb_pkg : shared types and constants for fifo_wr_arbiter         |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
`default_nettype none

package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  localparam int STATS_W = 16;

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
// +----------------------------------------------------------------------+
// | fifo_wr_arbiter_if : producer and FIFO write-port bundle              |
// | Optional stall_cycles port with FIFO_ARB_STATS_EN. Revision: 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_din;
  logic [ID_W-1:0]          grant_id;
  logic                     busy;
`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0]       stall_cycles;
`endif

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din, grant_id, busy
`ifdef FIFO_ARB_STATS_EN
    , input stall_cycles
`endif
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_din, grant_id, busy
`ifdef FIFO_ARB_STATS_EN
    , output stall_cycles
`endif
  );

endinterface

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin search starting at ptr            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    pick,
  output logic               any
);

  logic [NUM_REQ-1:0] w_rot;
  int                 w_off;
  int                 w_sum;

  // Rotate so that bit 0 is the ptr position, encode lowest set, then unrotate.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = i + int'(ptr);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      w_rot[i] = req[idx];
    end
  end

  always_comb begin
    w_off = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i;
    end
  end

  always_comb begin
    w_sum = int'(ptr) + w_off;
    if (w_sum >= NUM_REQ) w_sum = w_sum - NUM_REQ;
  end

  assign pick = ID_W'(w_sum);
  assign any  = |req;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// +----------------------------------------------------------------------+
// | fifo_wr_arbiter : round-robin burst-locking arbiter for a FIFO write  |
// | port. FIFO_ARB_STATS_EN adds a saturating stall counter. Rev: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int BURST   = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(BURST + 1);

  arb_state_t         r_state;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_beat_cnt;

  logic [ID_W-1:0]    w_pick;
  logic               w_any;
  logic               w_lock;
  logic               w_owner_valid;
  logic               w_xfer;
  logic               w_last_beat;
  logic [ID_W-1:0]    w_next_ptr;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req  (bus.req_valid),
    .ptr  (r_rr_ptr),
    .pick (w_pick),
    .any  (w_any)
  );

  assign w_lock        = (r_state == ARB_LOCK);
  assign w_owner_valid = bus.req_valid[r_owner];
  assign w_xfer        = w_lock && w_owner_valid && !bus.fifo_full;
  assign w_last_beat   = (r_beat_cnt == CNT_W'(BURST - 1));
  assign w_next_ptr    = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

  assign bus.req_ready  = w_xfer ? (NUM_REQ'(1) << r_owner) : '0;
  assign bus.fifo_wr_en = w_xfer;
  assign bus.fifo_din   = w_xfer ? bus.req_data[int'(r_owner)*WIDTH +: WIDTH] : '0;
  assign bus.busy       = w_lock;
  assign bus.grant_id   = r_owner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_owner    <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= ARB_LOCK;
          end
        end
        ARB_LOCK: begin
          // Dropping valid forfeits the rest of the burst.
          if (!w_owner_valid) begin
            r_state  <= ARB_IDLE;
            r_rr_ptr <= w_next_ptr;
          end else if (!bus.fifo_full) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_last_beat) begin
              r_state  <= ARB_IDLE;
              r_rr_ptr <= w_next_ptr;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STATS_W-1:0] r_stall_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_lock && w_owner_valid && bus.fifo_full && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_fifo_wr_arbiter : directed + random bench with reference model     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .BURST(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the port, beats used, next search start.
  bit m_busy;
  int m_owner, m_beats, m_ptr, m_stall;

  int       seq[N];
  int       exp_seq[N];
  logic [N-1:0] valid;
  logic     full;
  int       writes;
  bit       prev_busy;
  int       grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] beat_value(input int p);
    return W'((p << 6) | (seq[p] & 63));
  endfunction

  task automatic drive();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = beat_value(i);
    bus.req_data  = d;
    bus.req_valid = valid;
    bus.fifo_full = full;
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_stall = 0;
    prev_busy = 0;
  endtask

  task automatic step();
    bit           ex_xfer;
    logic [N-1:0] ex_rdy;
    logic [W-1:0] ex_din;
    int           p;
    bit           found;
    drive();
    @(negedge clk);
    ex_xfer = m_busy && valid[m_owner] && !full;
    ex_rdy  = ex_xfer ? (N'(1) << m_owner) : '0;
    ex_din  = ex_xfer ? beat_value(m_owner) : '0;
    chk("busy",     32'(bus.busy),       32'(m_busy));
    chk("grant_id", 32'(bus.grant_id),   32'(m_owner));
    chk("req_ready",32'(bus.req_ready),  32'(ex_rdy));
    chk("wr_en",    32'(bus.fifo_wr_en), 32'(ex_xfer));
    chk("din",      32'(bus.fifo_din),   32'(ex_din));
    chk("rdy_while_full", 32'((|bus.req_ready) & full), 32'(0));
`ifdef FIFO_ARB_STATS_EN
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall));
`endif
    if (bus.fifo_wr_en === 1'b1) begin
      p = int'(bus.fifo_din[7:6]);
      chk("order", 32'(bus.fifo_din[5:0]), 32'(exp_seq[p] & 63));
      exp_seq[p]++;
      writes++;
    end
    if (bus.busy === 1'b1 && !prev_busy) grants.push_back(int'(bus.grant_id));
    prev_busy = (bus.busy === 1'b1);
    @(posedge clk);
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && valid[idx]) begin
          m_owner = idx;
          found = 1;
        end
      end
      if (found) begin m_busy = 1; m_beats = 0; end
    end else if (!valid[m_owner]) begin
      m_busy = 0;
      m_ptr = (m_owner + 1) % N;
    end else if (full) begin
      if (m_stall < 65535) m_stall++;
    end else begin
      m_beats++;
      seq[m_owner]++;
      if (m_beats == B) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy",  32'(bus.busy),       32'(0));
    chk("rst_ready", 32'(bus.req_ready),  32'(0));
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 32'(0));
    chk("rst_din",   32'(bus.fifo_din),   32'(0));
    chk("rst_grant", 32'(bus.grant_id),   32'(0));
    model_reset();
    valid = '0;
    full  = 1'b0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int w0, w20, cyc;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    valid = '0; full = 1'b0; writes = 0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; exp_seq[i] = 0; end
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(); step();

    // Reset mid-burst with owner 2 after two beats
    valid = 4'b0100;
    step(); step(); step();
    chk("mid_owner", 32'(bus.grant_id), 32'(2));
    do_reset();
    valid = 4'b1111;
    step();
    chk("post_rst_grant", 32'(bus.grant_id), 32'(0));
    step();

    // Rotation with all producers active
    do_reset();
    valid = 4'b1111;
    grants.delete();
    w0 = writes;
    w20 = 0;
    for (int c = 0; c < 22; c++) begin
      step();
      if (c == 19) w20 = writes - w0;
    end
    chk("rot_writes_20", 32'(w20), 32'(16));
    chk("rot_grants_n", 32'(grants.size()), 32'(5));
    for (int k = 0; k < 5 && k < grants.size(); k++) chk("rot_order", 32'(grants[k]), 32'(exp_g[k]));

    // Truncated burst from producer 1
    do_reset();
    w0 = writes;
    valid = 4'b0010;
    step(); step(); step();
    valid = 4'b0000;
    step(); step();
    chk("trunc_writes", 32'(writes - w0), 32'(2));
    chk("trunc_idle", 32'(bus.busy), 32'(0));
    valid = 4'b1111;
    step();
    chk("trunc_next_grant", 32'(bus.grant_id), 32'(2));
    chk("trunc_next_busy", 32'(bus.busy), 32'(1));
    step();

    // FIFO full stall mid-burst
    do_reset();
    w0 = writes;
    valid = 4'b0001;
    step(); step(); step();
    full = 1'b1;
    repeat (5) step();
    chk("stall_writes", 32'(writes - w0), 32'(2));
    full = 1'b0;
    step(); step(); step();
    chk("stall_total_writes", 32'(writes - w0), 32'(4));
`ifdef FIFO_ARB_STATS_EN
    chk("stall_count5", 32'(bus.stall_cycles), 32'(5));
`endif

    // Late requester wins over owner's re-request
    do_reset();
    valid = 4'b0001;
    step(); step();
    valid = 4'b1001;
    step(); step(); step(); step();
    chk("late_grant", 32'(bus.grant_id), 32'(3));
    chk("late_busy", 32'(bus.busy), 32'(1));

    // Random traffic from producers 0..2
    do_reset();
    w0 = writes;
    cyc = 0;
    while ((writes - w0) < 64 && cyc < 3000) begin
      for (int i = 0; i < 3; i++) begin
        if (valid[i]) begin
          if ($urandom_range(0, 9) == 0) valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          valid[i] = 1'b1;
        end
      end
      valid[3] = 1'b0;
      full = ($urandom_range(0, 3) == 0);
      step();
      cyc++;
    end
    chk("rand_done", 32'((writes - w0) >= 64), 32'(1));
    for (int i = 0; i < N; i++) chk("no_loss", 32'(exp_seq[i]), 32'(seq[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
